pipe_stage_buf: RTL and testbench
=================================

# pipe_stage_buf

Parametrised, handshaked pipeline-stage register for the RISC-V datapath, the generalised successor to the fixed IF/ID, ID/EX, EX/MEM and MEM/WB buffer registers. It carries a W-bit packed payload between two stages with valid/ready flow control, hazard-unit stall and branch/jump flush, an optional two-entry skid buffer, and a saturating hold-cycle counter for performance analysis. One instance replaces each hand-written stage register; the payload is the packed stage struct cast to W bits.

## Interface
- W, 41, payload width in bits; 41 = 9-bit PC + 32-bit instruction, the IF/ID payload
- RESET_VAL, '0, W-bit value loaded into payload registers on reset and flush
- CNT_W, 16, hold-counter width
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  upstream presents payload
- in_data  in  W  upstream payload
- in_ready  out  1  stage accepts payload this cycle
- out_valid  out  1  payload presented downstream
- out_data  out  W  downstream payload
- out_ready  in  1  downstream accepts payload
- stall  in  1  hazard-unit freeze
- flush  in  1  kill contents (taken branch/jump)
- hold_cnt  out  CNT_W  saturating count of hold cycles

## Operation
- Accept: in_valid & in_ready. Deliver: out_valid & out_ready.
- States: EMPTY (no entry), FULL (main entry valid), SKID (main + skid valid; only with the skid buffer).
- EMPTY: accept -> FULL.
- FULL: deliver with no accept -> EMPTY. Deliver with accept -> FULL, new data. Accept with no deliver -> SKID when the skid buffer is present. Without the skid buffer, in_ready is 0 in this case.
- SKID: deliver -> FULL; the skid entry moves to main in the same edge. in_ready is 0.
- stall=1: in_ready=0 and out_valid=0, so a bubble is presented downstream. All entries and state hold.
- flush=1 has priority over stall, accept and deliver. Next state is EMPTY. Payload registers load RESET_VAL.
  - A payload accepted in the flush cycle is dropped.
  - in_ready during flush is its normal value, so upstream may complete a handshake that is discarded.
- hold_cnt increments each cycle that either:
  - stall=1 with state != EMPTY, or
  - out_valid=1 with out_ready=0.
- hold_cnt saturates at 2^CNT_W-1 and never wraps. It is cleared only by reset; flush does not clear it.
- out_data is the main-entry register. It is stable while out_valid & !out_ready.

## Timing
- Latency: 1 cycle. Data accepted at edge n is on out_data with out_valid=1 after edge n.
- Throughput: 1 transfer per cycle when out_ready=1 and stall=0.
- Reset values:
  - state EMPTY
  - out_valid 0
  - out_data RESET_VAL
  - skid entry RESET_VAL
  - in_ready 1
  - hold_cnt 0
- Reset asserted mid-transfer overrides everything. Outputs take reset values after that edge.
- Simultaneous flush and stall: flush wins, and the stage is EMPTY next cycle.
- Simultaneous accept and deliver in FULL: no state change, and the payload is replaced.

## Configuration
- PIPE_BUF_SKID_EN defined:
  - Two-entry skid buffer; SKID state exists.
  - in_ready is registered, equal to (state != SKID) & !stall.
  - No combinational path from out_ready to in_ready.
- PIPE_BUF_SKID_EN undefined:
  - Single entry.
  - in_ready = !stall & (!out_valid_int | out_ready), where out_valid_int is the main-entry valid bit. This is combinational from out_ready.
  - SKID is unreachable, and the skid registers are not instantiated.

## Structure
- The existing stage-register package, Pipe_Buf_Reg_PKG, gains:
  - typedef enum logic [1:0] pipe_buf_state_t {EMPTY, FULL, SKID}
  - PIPE_BUF_CNT_W_DEF = 16
  - The existing stage structs, so callers cast them to W bits.
- One sub-module, pipe_sat_counter, parametrised by width, with inputs clk, reset, inc and output count. It implements hold_cnt.

## Test plan
- Reset: hold reset 2 cycles. Then out_valid=0, out_data=RESET_VAL, in_ready=1, hold_cnt=0.
- Streaming: in_valid=1 with data 1..8 on consecutive cycles, out_ready=1. out_data is 1..8 one cycle later, no gaps, hold_cnt=0.
- Backpressure, skid enabled: accept 0x0A, drop out_ready, accept 0x0B. in_ready then goes 0. Raise out_ready: deliveries are 0x0A then 0x0B, and hold_cnt=1.
- Stall: in FULL with payload 0x55, stall=1 for 3 cycles. out_valid=0 and in_ready=0 throughout. After release, 0x55 is delivered and hold_cnt=3.
- Flush: FULL with in_valid=1, then flush=1 and stall=1 in the same cycle. Next cycle EMPTY, out_valid=0, out_data=RESET_VAL, and the incoming payload is never delivered.
- Saturation: CNT_W=4, out_ready=0 in FULL for 20 cycles. hold_cnt stops at 15.

Source files
------------

// File: rtl/pipe_stage_buf_pkg.sv
// ---------------------------------------------------------------------------
// Pipe_Buf_Reg_PKG -- shared types for the datapath stage registers.
//
// Holds the stage-buffer FSM encoding, the default hold-counter width and the
// packed stage structs that callers cast to W bits before handing them to a
// pipe_stage_buf instance.
// ---------------------------------------------------------------------------
package Pipe_Buf_Reg_PKG;

  // EMPTY: no entry, FULL: main entry valid, SKID: main + skid entries valid.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } pipe_buf_state_t;

  localparam int PIPE_BUF_CNT_W_DEF = 16;

  // IF/ID payload: fetch PC plus the raw instruction word.
  typedef struct packed {
    logic [8:0]  pc;
    logic [31:0] instr;
  } if_id_t;

  // The IF/ID payload is the widest fixed stage buffer and the default width.
  localparam int PIPE_BUF_W_DEF = $bits(if_id_t);

endpackage

// File: rtl/pipe_sat_counter.sv
// ---------------------------------------------------------------------------
// pipe_sat_counter -- saturating up-counter.
//
// Counts cycles with inc=1 and sticks at all-ones; never wraps.
//
// Ports:
//   clk    in   clock, rising edge
//   reset  in   synchronous active-high reset, clears count
//   inc    in   increment request for this cycle
//   count  out  current count (WIDTH bits)
// ---------------------------------------------------------------------------
module pipe_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] COUNT_MAX = '1;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != COUNT_MAX)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_buf.sv
// ---------------------------------------------------------------------------
// pipe_stage_buf -- handshaked pipeline-stage register.
//
// Carries a W-bit payload between two datapath stages with valid/ready flow
// control, hazard stall, branch/jump flush and a saturating hold counter.
//
// Handshake: a transfer happens on a rising edge where valid & ready are both
// high on that side (accept = in_valid & in_ready, deliver = out_valid &
// out_ready). Valid never waits on ready; data is held stable while
// valid & !ready.
//
// Build option: define PIPE_BUF_SKID_EN for a two-entry skid buffer with a
// registered in_ready (no out_ready -> in_ready path). Without it the stage
// holds one entry and in_ready is combinational from out_ready.
//
// Ports:
//   clk        in   clock, rising edge
//   reset      in   synchronous active-high reset
//   in_valid   in   upstream presents payload
//   in_data    in   upstream payload (W)
//   in_ready   out  stage accepts payload this cycle
//   out_valid  out  payload presented downstream (forced low by stall)
//   out_data   out  main-entry payload register (W)
//   out_ready  in   downstream accepts payload
//   stall      in   hazard-unit freeze: bubble downstream, hold contents
//   flush      in   kill contents; overrides stall, accept and deliver
//   hold_cnt   out  saturating count of hold cycles (CNT_W)
// ---------------------------------------------------------------------------
module pipe_stage_buf
  import Pipe_Buf_Reg_PKG::*;
#(
  parameter int           W         = PIPE_BUF_W_DEF,
  parameter logic [W-1:0] RESET_VAL = '0,
  parameter int           CNT_W     = PIPE_BUF_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [W-1:0]     in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [W-1:0]     out_data,
  input  logic             out_ready,
  input  logic             stall,
  input  logic             flush,
  output logic [CNT_W-1:0] hold_cnt
);

  localparam logic [1:0] ST_EMPTY = EMPTY;
  localparam logic [1:0] ST_FULL  = FULL;
`ifdef PIPE_BUF_SKID_EN
  localparam logic [1:0] ST_SKID  = SKID;
`endif

  logic [1:0]   state_q, state_d;
  logic [W-1:0] main_q, main_d;
  logic         main_valid;
  logic         accept;
  logic         deliver;
  logic         hold_inc;

  assign main_valid = (state_q != ST_EMPTY);
  assign out_valid  = main_valid & ~stall;
  assign out_data   = main_q;
  assign accept     = in_valid & in_ready;
  assign deliver    = out_valid & out_ready;

  // A hold cycle is either a stall over live contents or downstream backpressure.
  assign hold_inc = (stall & main_valid) | (out_valid & ~out_ready);

`ifdef PIPE_BUF_SKID_EN
  logic [W-1:0] skid_q, skid_d;
  logic         in_ready_q;

  // The registered part only depends on state, so out_ready never reaches
  // in_ready combinationally; stall still gates it in the same cycle.
  assign in_ready = in_ready_q & ~stall;
`else
  assign in_ready = ~stall & (~main_valid | out_ready);
`endif

  // Stall needs no explicit branch: it forces accept and deliver low, so
  // every arm below falls through to "hold".
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
`ifdef PIPE_BUF_SKID_EN
    skid_d  = skid_q;
`endif
    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = RESET_VAL;
`ifdef PIPE_BUF_SKID_EN
      skid_d  = RESET_VAL;
`endif
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d = ST_FULL;
            main_d  = in_data;
          end
        end
        ST_FULL: begin
          if (deliver && accept) begin
            main_d = in_data;
          end else if (deliver) begin
            state_d = ST_EMPTY;
`ifdef PIPE_BUF_SKID_EN
          end else if (accept) begin
            state_d = ST_SKID;
            skid_d  = in_data;
`endif
          end
        end
`ifdef PIPE_BUF_SKID_EN
        ST_SKID: begin
          // in_ready is low here, so only a delivery can move the stage.
          if (deliver) begin
            state_d = ST_FULL;
            main_d  = skid_q;
          end
        end
`endif
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      main_q  <= RESET_VAL;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
    end
  end

`ifdef PIPE_BUF_SKID_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      skid_q     <= RESET_VAL;
      in_ready_q <= 1'b1;
    end else begin
      skid_q     <= skid_d;
      in_ready_q <= (state_d != ST_SKID);
    end
  end
`endif

  pipe_sat_counter #(
    .WIDTH (CNT_W)
  ) u_hold_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (hold_inc),
    .count (hold_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_buf.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_buf -- self-checking bench for pipe_stage_buf.
//
// Directed vectors with hand-computed expectations. Expected deliveries are
// queued by the stimulus; a negedge monitor pops and compares each completed
// downstream handshake. CNT_W is 4 so saturation is reachable quickly, and a
// non-zero RESET_VAL makes reset/flush loads observable.
// ---------------------------------------------------------------------------
module tb_pipe_stage_buf;

  localparam int           W     = 41;
  localparam int           CNT_W = 4;
  localparam logic [W-1:0] RST   = 41'h1_2345_6789;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic [W-1:0]     in_data;
  logic             in_ready;
  logic             out_valid;
  logic [W-1:0]     out_data;
  logic             out_ready;
  logic             stall;
  logic             flush;
  logic [CNT_W-1:0] hold_cnt;

  logic [W-1:0] exp_q[$];
  int           n_tests;
  int           n_fail;

  pipe_stage_buf #(
    .W         (W),
    .RESET_VAL (RST),
    .CNT_W     (CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .stall     (stall),
    .flush     (flush),
    .hold_cnt  (hold_cnt)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver / check tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    stall     = 1'b0;
    flush     = 1'b0;
    tick();
    reset = 1'b0;
    #1;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_delivery", 64'(out_data), 64'(RST) ^ 64'h1);
      end else begin
        check("delivery", 64'(out_data), 64'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    n_tests   = 0;
    n_fail    = 0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    stall     = 1'b0;
    flush     = 1'b0;

    // Reset held for two cycles.
    tick();
    tick();
    reset = 1'b0;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data",  64'(out_data),  64'(RST));
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_hold_cnt",  64'(hold_cnt),  64'd0);

    // Streaming 1..8 back to back, one-cycle latency, no gaps.
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_data  = W'(i);
      exp_q.push_back(W'(i));
      tick();
      check("stream_valid", 64'(out_valid), 64'd1);
      check("stream_data",  64'(out_data),  64'(i));
    end
    in_valid = 1'b0;
    tick();
    check("stream_drained", 64'(out_valid), 64'd0);
    check("stream_hold",    64'(hold_cnt),  64'd0);

    // Backpressure: 0x0A held, 0x0B offered while downstream is stalled.
    do_reset();
    in_valid = 1'b1;
    in_data  = W'(8'h0A);
    exp_q.push_back(W'(8'h0A));
    #1;
    check("bp_ready_empty", 64'(in_ready), 64'd1);
    tick();
    in_data = W'(8'h0B);
    exp_q.push_back(W'(8'h0B));
    #1;
`ifdef PIPE_BUF_SKID_EN
    check("bp_ready_full_skid", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    #1;
    check("bp_ready_skid", 64'(in_ready), 64'd0);
    check("bp_hold_data",  64'(out_data), 64'h0A);
    out_ready = 1'b1;
    tick();
`else
    check("bp_ready_full", 64'(in_ready), 64'd0);
    tick();
    check("bp_hold_data", 64'(out_data), 64'h0A);
    out_ready = 1'b1;
    #1;
    check("bp_ready_comb", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
`endif
    check("bp_second_data", 64'(out_data), 64'h0B);
    tick();
    check("bp_hold_cnt",  64'(hold_cnt),  64'd1);
    check("bp_drained",   64'(out_valid), 64'd0);

    // Stall for three cycles over a full stage holding 0x55.
    do_reset();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = W'(8'h55);
    exp_q.push_back(W'(8'h55));
    tick();
    in_valid = 1'b0;
    stall    = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("stall_out_valid", 64'(out_valid), 64'd0);
      check("stall_in_ready",  64'(in_ready),  64'd0);
      check("stall_data",      64'(out_data),  64'h55);
      tick();
    end
    stall = 1'b0;
    #1;
    check("stall_release_valid", 64'(out_valid), 64'd1);
    tick();
    check("stall_hold_cnt", 64'(hold_cnt),  64'd3);
    check("stall_drained",  64'(out_valid), 64'd0);

    // Flush together with stall while full and offered new data.
    do_reset();
    in_valid = 1'b1;
    in_data  = W'(8'h77);
    tick();
    in_data = W'(8'h99);
    flush   = 1'b1;
    stall   = 1'b1;
    tick();
    flush    = 1'b0;
    stall    = 1'b0;
    in_valid = 1'b0;
    #1;
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_out_data",  64'(out_data),  64'(RST));
    check("flush_hold_kept", 64'(hold_cnt),  64'd1);
    check("flush_in_ready",  64'(in_ready),  64'd1);
    out_ready = 1'b1;
    tick();
    tick();
    // Handshake completed during a flush from empty is discarded.
    in_valid = 1'b1;
    in_data  = W'(8'h33);
    flush    = 1'b1;
    #1;
    check("flush_ready_normal", 64'(in_ready), 64'd1);
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    #1;
    check("flush_drop", 64'(out_valid), 64'd0);
    tick();

    // Hold counter saturation (CNT_W = 4) over 20 backpressured cycles.
    do_reset();
    in_valid = 1'b1;
    in_data  = W'(8'h3C);
    exp_q.push_back(W'(8'h3C));
    tick();
    in_valid = 1'b0;
    repeat (20) tick();
    check("sat_hold_cnt",  64'(hold_cnt),  64'd15);
    check("sat_data",      64'(out_data),  64'h3C);
    check("sat_out_valid", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    tick();
    check("sat_hold_stuck", 64'(hold_cnt),  64'd15);
    check("sat_drained",    64'(out_valid), 64'd0);

    // Reset in the middle of a held transfer.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = W'(16'h1234);
    tick();
    reset   = 1'b1;
    in_data = W'(16'h5678);
    tick();
    reset    = 1'b0;
    in_valid = 1'b0;
    #1;
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_out_data",  64'(out_data),  64'(RST));
    check("mid_rst_hold_cnt",  64'(hold_cnt),  64'd0);
    check("mid_rst_in_ready",  64'(in_ready),  64'd1);
    tick();

    // ---------------- final report ----------------
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
